// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locking arbiter for the single FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add per-producer beat counters and a stall counter.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          almostfull,
  input  logic                          overflow,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]         beat_cnt,
  output logic [31:0]                   stall_cnt,
`endif
  output logic                          err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  // state    | meaning
  // ST_IDLE  | no owner; arbitrate from r_rr_ptr
  // ST_BURST | r_owner holds the port; r_cnt beats granted so far
  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_owner, w_owner_nxt;
  logic [IDX_W-1:0]      r_rr_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_wr_en, r_wr_en_d;
  logic [FIFO_WIDTH-1:0] r_data_in;
  logic                  r_err;

  logic                  w_can_write;
  logic [IDX_W-1:0]      w_search_ptr, w_scan, w_sel_idx, w_gidx;
  logic                  w_sel_found, w_arb;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_beat;
  logic [FIFO_WIDTH-1:0] w_gnt_data;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (v == LAST_IDX) wrap_inc = '0;
    else               wrap_inc = v + 1'b1;
  endfunction

  // almostfull with a write already in flight means the FIFO may be full next cycle
  assign w_can_write  = rst_n && !full && !(almostfull && r_wr_en);
  assign w_search_ptr = (r_state == ST_BURST) ? wrap_inc(r_owner) : r_rr_ptr;

  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_scan      = w_search_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_sel_found && req[w_scan]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_scan;
      end
      w_scan = wrap_inc(w_scan);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_rr_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt       = '0;
    w_gidx      = r_owner;
    w_arb       = 1'b0;
    case (r_state)
      ST_IDLE: w_arb = 1'b1;
      ST_BURST: begin
        if (!req[r_owner]) begin
          w_arb       = 1'b1;
          w_ptr_nxt   = wrap_inc(r_owner);
          w_state_nxt = ST_IDLE;
        end else if (w_can_write) begin
          if (r_cnt < BURST_MAX) begin
            w_gnt[r_owner] = 1'b1;
            w_cnt_nxt      = r_cnt + 1'b1;
          end else begin
            w_arb       = 1'b1;
            w_ptr_nxt   = wrap_inc(r_owner);
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // same-cycle re-arbitration keeps back-to-back bursts bubble-free
    if (w_arb && w_sel_found && w_can_write) begin
      w_gnt[w_sel_idx] = 1'b1;
      w_gidx           = w_sel_idx;
      w_state_nxt      = ST_BURST;
      w_owner_nxt      = w_sel_idx;
      w_cnt_nxt        = CNT_W'(1);
    end
  end

  assign w_beat     = |(w_gnt & req);
  assign w_gnt_data = req_data[w_gidx*FIFO_WIDTH +: FIFO_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_en_d <= 1'b0;
      r_data_in <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_ptr  <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_en   <= w_beat;
      r_wr_en_d <= r_wr_en;
      if (w_beat) r_data_in <= w_gnt_data;
      if (overflow && r_wr_en_d) r_err <= 1'b1;
    end
  end

  assign gnt     = w_gnt;
  assign wr_en   = r_wr_en;
  assign data_in = r_data_in;
  assign owner   = r_owner;
  assign err     = r_err;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*32-1:0] r_beat_cnt;
  logic [31:0]           r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt[i] && req[i]) r_beat_cnt[i*32 +: 32] <= r_beat_cnt[i*32 +: 32] + 32'd1;
      end
      if ((|req) && (w_gnt == '0)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign beat_cnt  = r_beat_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
